sram_mem_controller: RTL and testbench
======================================

// Module: sram_mem_controller
// PURPOSE
//  Multi-cycle controller between the MEM stage and a 16-bit asynchronous off-chip SRAM.
//  Takes the decoder's mem_read/mem_write request and sequences one 32-bit word as two
//  16-bit SRAM accesses, low half first.
//  Drives ready low while busy; the pipeline uses freeze = ~ready.
// PARAMETERS
//  ADDR_BASE     1024  first byte address of data memory; subtracted before indexing
//  SRAM_AW       18    SRAM word-address width
//  PHASE_CYCLES  2     clock cycles held per half-word access (>=1)
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst          in   1   asynchronous, active-high reset
//  wr_en        in   1   store request (mem_write), held until ready
//  rd_en        in   1   load request (mem_read), held until ready
//  address      in   32  byte address (ALU result), held until ready
//  write_data   in   32  store data, held until ready
//  read_data    out  32  load result; valid in DONE, held until the next read completes
//  ready        out  1   1 = no pending access or access finishing this cycle
//  sram_addr    out  18  SRAM half-word address
//  sram_dq_out  out  16  write data to SRAM
//  sram_dq_in   in   16  read data from SRAM
//  sram_dq_oe   out  1   1 = controller drives DQ bus (tri-state enable at top level)
//  sram_we_n    out  1   SRAM write strobe, active low
//  sram_oe_n    out  1   SRAM output enable, active low
// BEHAVIOUR
//  Reset values (asynchronous, any state, including mid-access):
//   - state=IDLE, phase counter=0, read_data=0, sram_addr=0, sram_dq_out=0.
//   - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
//  States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
//  IDLE:
//   - wr_en=1 -> WR_LO, with priority over rd_en.
//   - else rd_en=1 -> RD_LO.
//   - else stay in IDLE.
//   - Entering WR_LO or RD_LO captures word index and write_data into internal registers.
//  Word index:
//   - widx = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits.
//   - Out-of-range addresses wrap modulo SRAM size; no error is flagged.
//  Half-word addresses: *_LO uses sram_addr={widx,1'b0}; *_HI uses {widx,1'b1}.
//  Phase timing: each *_LO/*_HI state lasts exactly PHASE_CYCLES cycles, counted by the phase counter.
//   - The counter resets to 0 on every state change.
//  WR_LO/WR_HI:
//   - sram_we_n=0, sram_dq_oe=1, sram_oe_n=1.
//   - sram_dq_out = write_data[15:0] in LO, [31:16] in HI.
//  RD_LO/RD_HI:
//   - sram_we_n=1, sram_dq_oe=0, sram_oe_n=0.
//   - sram_dq_in is sampled on the last cycle of the phase into read_data[15:0] (LO) or [31:16] (HI).
//  DONE: SRAM strobes inactive; ready=1 for exactly this one cycle; always goes to IDLE next.
//  ready (combinational) = (state==IDLE && !wr_en && !rd_en) || state==DONE.
//   - A request seen in IDLE drops ready in the same cycle, freezing the pipeline at the next edge.
//  Latency: request present in cycle 0 -> ready=1 in cycle 2*PHASE_CYCLES+1 (cycle 5 at default).
//   - Back-to-back requests: ready returns to 0 in the IDLE cycle after DONE.
//  Requests that change or drop mid-access are ignored; the captured operation completes.
//  sram_dq_out changes only when sram_we_n is high or at a phase boundary, never mid-phase.
//  All SRAM-side outputs are registered (no glitches).
// STRUCTURE
//  Shared package:
//   - state encoding typedef (3-bit).
//   - ADDR_BASE default.
//   - HALF_W=16 constant, reused by the SRAM behavioural model.
//  No sub-module: phase counter and FSM stay inline; the tri-state buffer lives at top level.
// TESTING (PHASE_CYCLES=2, ADDR_BASE=1024, behavioural SRAM model on the bench)
//  1. No request after reset -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0 on every cycle.
//  2. wr_en, address=1024, data=0xDEADBEEF at cycle 0:
//     -> sram_addr=0, dq=0xBEEF, we_n=0 in cycles 1-2.
//     -> sram_addr=1, dq=0xDEAD in cycles 3-4.
//     -> ready=1 in cycle 5 only.
//  3. rd_en, address=1024 after test 2 -> read_data=0xDEADBEEF in cycle 5; ready=0 in cycles 0-4.
//  4. wr_en, address=1028, data=0x12345678 -> SRAM[2]=0x5678, SRAM[3]=0x1234; read back matches.
//  5. rd_en=wr_en=1, address=1032, data=0xA5A5A5A5 -> write performed, SRAM[4..5]=0xA5A5; read_data unchanged.
//  6. rst pulsed in cycle 3 of a write -> outputs at reset values immediately; ready=1 after release.
//     SRAM[1] not written after the pulse.

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_controller_pkg
// Description : Shared types and constants for the MEM-stage SRAM controller
//               and its behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_mem_controller_pkg;

    // First byte address of data memory.
    localparam int unsigned c_addr_base = 1024;

    // SRAM data-bus width and pipeline word width.
    localparam int unsigned c_half_w = 16;
    localparam int unsigned c_word_w = 32;

    // Controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR_LO = 3'd1,
        ST_WR_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_RD_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage : sram_mem_controller_pkg
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_controller
// Description : Sequences one 32-bit load/store as two 16-bit accesses to an
//               asynchronous SRAM (low half first). ready is low while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned ADDR_BASE    = c_addr_base,
    parameter int unsigned SRAM_AW      = 18,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [c_word_w-1:0] address,
    input  logic [c_word_w-1:0] write_data,
    output logic [c_word_w-1:0] read_data,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [c_half_w-1:0] sram_dq_out,
    input  logic [c_half_w-1:0] sram_dq_in,
    output logic                sram_dq_oe,
    output logic                sram_we_n,
    output logic                sram_oe_n
);

    localparam int unsigned c_cnt_w  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int unsigned c_widx_w = SRAM_AW - 1;
    localparam logic [c_cnt_w-1:0] c_phase_last = c_cnt_w'(PHASE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_phase;
    logic                  w_phase_done;
    logic                  w_timed;

    logic [c_widx_w-1:0]   w_addr_widx;
    logic [c_widx_w-1:0]   r_widx;
    logic [c_widx_w-1:0]   w_widx_nxt;
    logic [c_word_w-1:0]   r_wdata;
    logic [c_word_w-1:0]   w_wdata_nxt;

    logic [c_word_w-1:0]   r_read_data;
    logic [SRAM_AW-1:0]    r_sram_addr;
    logic [SRAM_AW-1:0]    w_sram_addr_nxt;
    logic [c_half_w-1:0]   r_sram_dq_out;
    logic [c_half_w-1:0]   w_sram_dq_out_nxt;
    logic                  r_sram_dq_oe;
    logic                  w_sram_dq_oe_nxt;
    logic                  r_sram_we_n;
    logic                  w_sram_we_n_nxt;
    logic                  r_sram_oe_n;
    logic                  w_sram_oe_n_nxt;

    // Word index relative to the data-memory base; wraps modulo SRAM size.
    assign w_addr_widx  = c_widx_w'((address - ADDR_BASE) >> 2);
    assign w_phase_done = (r_phase == c_phase_last);
    assign w_timed      = (r_state != ST_IDLE) && (r_state != ST_DONE);

    // Next-state, operand capture and next registered SRAM-side outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_widx_nxt        = r_widx;
        w_wdata_nxt       = r_wdata;
        w_sram_addr_nxt   = r_sram_addr;
        w_sram_dq_out_nxt = r_sram_dq_out;
        w_sram_dq_oe_nxt  = 1'b0;
        w_sram_we_n_nxt   = 1'b1;
        w_sram_oe_n_nxt   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                // Stores win when both requests are present.
                if (wr_en) begin
                    w_state_nxt = ST_WR_LO;
                    w_widx_nxt  = w_addr_widx;
                    w_wdata_nxt = write_data;
                end else if (rd_en) begin
                    w_state_nxt = ST_RD_LO;
                    w_widx_nxt  = w_addr_widx;
                    w_wdata_nxt = write_data;
                end
            end
            ST_WR_LO: if (w_phase_done) w_state_nxt = ST_WR_HI;
            ST_WR_HI: if (w_phase_done) w_state_nxt = ST_DONE;
            ST_RD_LO: if (w_phase_done) w_state_nxt = ST_RD_HI;
            ST_RD_HI: if (w_phase_done) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        // Outputs follow the state being entered so they are registered
        // alongside it; DQ data only moves at phase boundaries.
        case (w_state_nxt)
            ST_WR_LO: begin
                w_sram_addr_nxt   = {w_widx_nxt, 1'b0};
                w_sram_dq_out_nxt = w_wdata_nxt[c_half_w-1:0];
                w_sram_dq_oe_nxt  = 1'b1;
                w_sram_we_n_nxt   = 1'b0;
            end
            ST_WR_HI: begin
                w_sram_addr_nxt   = {w_widx_nxt, 1'b1};
                w_sram_dq_out_nxt = w_wdata_nxt[c_word_w-1:c_half_w];
                w_sram_dq_oe_nxt  = 1'b1;
                w_sram_we_n_nxt   = 1'b0;
            end
            ST_RD_LO: begin
                w_sram_addr_nxt = {w_widx_nxt, 1'b0};
                w_sram_oe_n_nxt = 1'b0;
            end
            ST_RD_HI: begin
                w_sram_addr_nxt = {w_widx_nxt, 1'b1};
                w_sram_oe_n_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // State, phase counter, captured operands and registered SRAM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_phase       <= '0;
            r_widx        <= '0;
            r_wdata       <= '0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= '0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_widx        <= w_widx_nxt;
            r_wdata       <= w_wdata_nxt;
            r_sram_addr   <= w_sram_addr_nxt;
            r_sram_dq_out <= w_sram_dq_out_nxt;
            r_sram_dq_oe  <= w_sram_dq_oe_nxt;
            r_sram_we_n   <= w_sram_we_n_nxt;
            r_sram_oe_n   <= w_sram_oe_n_nxt;
            if (w_state_nxt != r_state) begin
                r_phase <= '0;
            end else if (w_timed) begin
                r_phase <= r_phase + c_cnt_w'(1);
            end
        end
    end

    // Load data: each half is sampled on the last cycle of its read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (w_phase_done) begin
            if (r_state == ST_RD_LO) begin
                r_read_data[c_half_w-1:0] <= sram_dq_in;
            end else if (r_state == ST_RD_HI) begin
                r_read_data[c_word_w-1:c_half_w] <= sram_dq_in;
            end
        end
    end

    assign ready       = ((r_state == ST_IDLE) && !wr_en && !rd_en) || (r_state == ST_DONE);
    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;
    assign sram_oe_n   = r_sram_oe_n;

endmodule : sram_mem_controller
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_mem_controller
// Description : Scoreboard bench for sram_mem_controller with a behavioural
//               16-bit asynchronous SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_controller;
    import sram_mem_controller_pkg::*;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic                rd_en;
    logic [31:0]         address;
    logic [31:0]         write_data;
    logic [31:0]         read_data;
    logic                ready;
    logic [17:0]         sram_addr;
    logic [c_half_w-1:0] sram_dq_out;
    logic [c_half_w-1:0] sram_dq_in;
    logic                sram_dq_oe;
    logic                sram_we_n;
    logic                sram_oe_n;

    sram_mem_controller #(
        .ADDR_BASE    (1024),
        .SRAM_AW      (18),
        .PHASE_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: writes while strobed and driven, reads when enabled.
    logic [c_half_w-1:0] mem [0:(1<<18)-1];
    initial begin
        for (int i = 0; i < (1 << 18); i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end
    always_comb begin
        sram_dq_in = 'x;
        if (!sram_oe_n && !sram_dq_oe) sram_dq_in = mem[sram_addr];
    end

    typedef struct {
        int          tst;
        int          cyc;
        bit          rdy;
        bit          we_n;
        bit          oe_n;
        bit          dq_oe;
        bit          ck_addr;
        logic [17:0] addr;
        bit          ck_dq;
        logic [15:0] dq;
        bit          ck_rd;
        logic [31:0] rd;
    } rec_t;

    rec_t        sb_q[$];
    rec_t        m_exp;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected bus/ready picture for cycle cyc (0 = request cycle) of an access.
    function automatic rec_t mk_rec(input int tst, input int cyc, input bit wr,
                                    input logic [31:0] addr, input logic [31:0] data,
                                    input logic [31:0] rd_exp);
        rec_t        r;
        logic [31:0] off;
        bit          hi;
        off       = (addr - 32'd1024) >> 2;
        hi        = (cyc >= 3);
        r.tst     = tst;   r.cyc   = cyc;
        r.rdy     = 1'b0;  r.we_n  = 1'b1;  r.oe_n = 1'b1;  r.dq_oe = 1'b0;
        r.ck_addr = 1'b0;  r.addr  = '0;
        r.ck_dq   = 1'b0;  r.dq    = '0;
        r.ck_rd   = 1'b0;  r.rd    = '0;
        if (cyc >= 1 && cyc <= 4) begin
            r.ck_addr = 1'b1;
            r.addr    = {off[16:0], hi};
            if (wr) begin
                r.we_n  = 1'b0;
                r.dq_oe = 1'b1;
                r.ck_dq = 1'b1;
                r.dq    = hi ? data[31:16] : data[15:0];
            end else begin
                r.oe_n = 1'b0;
            end
        end else if (cyc == 5) begin
            r.rdy   = 1'b1;
            r.ck_rd = 1'b1;
            r.rd    = rd_exp;
        end
        return r;
    endfunction

    // Monitor: every sampled cycle with a pending expectation is compared.
    always begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
            m_exp = sb_q.pop_front();
            n_vec++;
            if ((ready !== m_exp.rdy) || (sram_we_n !== m_exp.we_n) ||
                (sram_oe_n !== m_exp.oe_n) || (sram_dq_oe !== m_exp.dq_oe) ||
                (m_exp.ck_addr && (sram_addr !== m_exp.addr)) ||
                (m_exp.ck_dq && (sram_dq_out !== m_exp.dq)) ||
                (m_exp.ck_rd && (read_data !== m_exp.rd))) begin
                n_miss++;
                $display("FAIL t%0d.c%0d: got rdy=%b we_n=%b oe_n=%b dq_oe=%b addr=%h dq=%h rd=%h expected rdy=%b we_n=%b oe_n=%b dq_oe=%b addr=%h(%0d) dq=%h(%0d) rd=%h(%0d)",
                         m_exp.tst, m_exp.cyc, ready, sram_we_n, sram_oe_n, sram_dq_oe,
                         sram_addr, sram_dq_out, read_data, m_exp.rdy, m_exp.we_n,
                         m_exp.oe_n, m_exp.dq_oe, m_exp.addr, m_exp.ck_addr,
                         m_exp.dq, m_exp.ck_dq, m_exp.rd, m_exp.ck_rd);
            end
        end
    end

    // Caller sits at posedge+1 of a free cycle on entry and on return.
    task automatic idle(input int tst, input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = mk_rec(tst, 0, 1'b0, 32'd1024, 32'h0, 32'h0);
            r.rdy = 1'b1;
            sb_q.push_back(r);
            @(posedge clk); #1;
        end
    endtask

    task automatic access(input int tst, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rd_exp, input bit glitch);
        logic [31:0] exp_rd;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        exp_rd     = wr ? last_rd : rd_exp;
        for (int c = 0; c <= 5; c++) sb_q.push_back(mk_rec(tst, c, wr, addr, data, exp_rd));
        last_rd = exp_rd;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (glitch && c == 1) begin
                address    = ~addr;
                write_data = ~data;
                wr_en      = 1'b0;
                rd_en      = 1'b0;
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        #1;
        check1("reset ready", {31'd0, ready}, 32'd1);
        check1("reset we_n", {31'd0, sram_we_n}, 32'd1);
        check1("reset oe_n", {31'd0, sram_oe_n}, 32'd1);
        check1("reset dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check1("reset read_data", read_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        idle(1, 4);
        access(2, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0);
        access(3, 1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0);
        access(4, 1'b1, 1'b0, 32'd1028, 32'h12345678, 32'h0, 1'b0);
        access(4, 1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 1'b0);
        check1("mem[2]", {16'h0, mem[2]}, 32'h5678);
        check1("mem[3]", {16'h0, mem[3]}, 32'h1234);
        access(5, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h0, 1'b0);
        check1("mem[4]", {16'h0, mem[4]}, 32'hA5A5);
        check1("mem[5]", {16'h0, mem[5]}, 32'hA5A5);
        // Below-base address wraps to the top of the SRAM.
        access(7, 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, 32'h0, 1'b0);
        access(7, 1'b0, 1'b1, 32'd1020, 32'h0, 32'hCAFEF00D, 1'b0);
        check1("mem[3FFFF]", {16'h0, mem[18'h3FFFF]}, 32'hCAFE);
        // Request operands change right after capture; captured store completes.
        access(8, 1'b1, 1'b0, 32'd1036, 32'h0F0FF0F0, 32'h0, 1'b1);
        access(8, 1'b0, 1'b1, 32'd1036, 32'h0, 32'h0F0FF0F0, 1'b0);
        idle(8, 2);

        // Reset pulse in cycle 3 of a store.
        wr_en      = 1'b1;
        address    = 32'd1024;
        write_data = 32'h11112222;
        for (int c = 0; c <= 2; c++) sb_q.push_back(mk_rec(6, c, 1'b1, 32'd1024, 32'h11112222, 32'h0));
        repeat (3) begin @(posedge clk); #1; end
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check1("rst we_n", {31'd0, sram_we_n}, 32'd1);
        check1("rst oe_n", {31'd0, sram_oe_n}, 32'd1);
        check1("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check1("rst sram_addr", {14'd0, sram_addr}, 32'd0);
        check1("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
        check1("rst read_data", read_data, 32'd0);
        check1("rst ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        idle(6, 3);
        check1("mem[0] after abort", {16'h0, mem[0]}, 32'h2222);
        check1("mem[1] after abort", {16'h0, mem[1]}, 32'hDEAD);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_sram_mem_controller
`default_nettype wire
